// File: rtl/hack_pkg.sv
// ============================================================================
// Module   : hack_pkg
// Purpose  : Hack platform memory-map constants and the scanout state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hack_pkg;
    localparam int SCREEN_BASE  = 16384;
    localparam int SCREEN_WORDS = 8192;
    localparam int KBD_ADDR     = 24576;
    localparam int HACK_ADDR_W  = 15;
    localparam int HACK_WORD_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_e;
endpackage

`default_nettype wire

// File: rtl/scanout_word_fifo.sv
// ============================================================================
// Module   : scanout_word_fifo
// Purpose  : Small synchronous word FIFO; push and pop may occur in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scanout_word_fifo
    import hack_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter int  WIDTH = HACK_WORD_W,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only when a pop frees the slot.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

`default_nettype wire

// File: rtl/screen_scanout.sv
// ============================================================================
// Module   : screen_scanout
// Purpose  : Fetches the Hack framebuffer over a request/grant read port and
//            serialises it into a valid/ready pixel stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module screen_scanout
    import hack_pkg::*;
#(
    parameter int BASE_ADDR      = SCREEN_BASE,
    parameter int WORDS_PER_LINE = 32,
    parameter int LINES          = 256,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    output logic                   rd_req,
    output logic [HACK_ADDR_W-1:0] rd_addr,
    input  logic                   rd_grant,
    input  logic [HACK_WORD_W-1:0] rd_data,
    output logic                   pix,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic                   pix_sof,
    output logic                   pix_eol
);
    localparam int FRAME_WORDS = WORDS_PER_LINE * LINES;
    localparam int LINE_PIX    = WORDS_PER_LINE * HACK_WORD_W;
    localparam int X_W         = $clog2(LINE_PIX);
    localparam int Y_W         = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1;

    localparam logic [HACK_ADDR_W-1:0] ADDR_FIRST = HACK_ADDR_W'(BASE_ADDR);
    localparam logic [HACK_ADDR_W-1:0] ADDR_LAST  = HACK_ADDR_W'(BASE_ADDR + FRAME_WORDS - 1);
    localparam logic [X_W-1:0]         X_LAST     = X_W'(LINE_PIX - 1);
    localparam logic [Y_W-1:0]         Y_LAST     = Y_W'(LINES - 1);

    scan_state_e            state_q;
    logic [HACK_ADDR_W-1:0] rd_addr_q;
    logic [HACK_ADDR_W-1:0] rd_addr_d;
    logic                   inflight_q;
    logic [HACK_WORD_W-1:0] shift_q;
    logic [4:0]             bitcnt_q;
    logic [X_W-1:0]         x_q;
    logic [Y_W-1:0]         y_q;

    logic [HACK_WORD_W-1:0] fifo_head;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   grant_fire;
    logic                   consume;
    logic                   load;

    assign rd_req     = (state_q == ST_RUN) &&
                        ((fifo_count + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH));
    assign rd_addr    = rd_addr_q;
    assign grant_fire = rd_req && rd_grant;
    assign rd_addr_d  = (rd_addr_q == ADDR_LAST) ? ADDR_FIRST : rd_addr_q + HACK_ADDR_W'(1);

    assign pix       = shift_q[0];
    assign pix_valid = (bitcnt_q != 5'd0);
    assign pix_sof   = pix_valid && (x_q == '0) && (y_q == '0);
    assign pix_eol   = pix_valid && (x_q == X_LAST);
    assign consume   = pix_valid && pix_ready;

    // Reload on the cycle the last bit leaves so a ready sink sees no bubble.
    assign load = !fifo_empty && ((bitcnt_q == 5'd0) || ((bitcnt_q == 5'd1) && consume));

    scanout_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (HACK_WORD_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (inflight_q),
        .wdata_i (rd_data),
        .pop_i   (load),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rd_addr_q  <= ADDR_FIRST;
            inflight_q <= 1'b0;
            shift_q    <= '0;
            bitcnt_q   <= 5'd0;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            inflight_q <= grant_fire;
            if (grant_fire) begin
                rd_addr_q <= rd_addr_d;
            end

            // enable is only honoured when the fetch pointer wraps to the frame start.
            case (state_q)
                ST_IDLE:  if (enable) state_q <= ST_RUN;
                ST_RUN:   if (grant_fire && (rd_addr_q == ADDR_LAST) && !enable) state_q <= ST_DRAIN;
                ST_DRAIN: if (!inflight_q && fifo_empty && (bitcnt_q == 5'd0)) state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase

            if (load) begin
                shift_q  <= fifo_head;
                bitcnt_q <= 5'd16;
            end else if (consume) begin
                shift_q  <= {1'b0, shift_q[HACK_WORD_W-1:1]};
                bitcnt_q <= bitcnt_q - 5'd1;
            end

            if (consume) begin
                if (x_q == X_LAST) begin
                    x_q <= '0;
                    y_q <= (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
                end else begin
                    x_q <= x_q + X_W'(1);
                end
            end
        end
    end

    a_addr_in_screen: assert property (@(posedge clk) disable iff (reset)
        (rd_addr_q >= ADDR_FIRST) && (rd_addr_q <= ADDR_LAST) &&
        (rd_addr_q < HACK_ADDR_W'(SCREEN_BASE + SCREEN_WORDS)) &&
        (rd_addr_q < HACK_ADDR_W'(KBD_ADDR)));

    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (reset)
        !(inflight_q && fifo_full && !load));
endmodule

`default_nettype wire
